// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, mispredict inputs and pipeline control outputs of pipe_ctrl
interface pipe_ctrl_if #(parameter int STALL_W = 6);
  logic rdy;
  logic if_stall_req;
  logic id_stall_req;
  logic mem_stall_req;
  logic if_busy;
  logic ex_mispredict;
  logic [31:0] ex_target;
  logic [STALL_W-1:0] stall_sign;
  logic flush;
  logic redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  modport master (
    output rdy, if_stall_req, id_stall_req, mem_stall_req, if_busy, ex_mispredict, ex_target,
    input stall_sign, flush, redirect_valid, redirect_addr, stall_cycles, flush_count
  );
  modport slave (
    input rdy, if_stall_req, id_stall_req, mem_stall_req, if_busy, ex_mispredict, ex_target,
    output stall_sign, flush, redirect_valid, redirect_addr, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merging, mispredict flush/drain/redirect sequencing and stall/flush statistics
module pipe_ctrl #(
  parameter int STALL_W = 6,
  parameter logic [31:0] STALL_CYCLES_INIT = '0,
  parameter logic [15:0] FLUSH_COUNT_INIT = '0
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.slave p
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  logic [1:0] state, state_nxt;
  logic take;
  logic [31:0] redirect_addr;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  always_comb begin
    p.stall_sign = !p.rdy ? {STALL_W{1'b1}} :
                   p.mem_stall_req ? STALL_W'(5'b11111) :
                   p.id_stall_req ? STALL_W'(3'b111) :
                   (p.if_stall_req || state == WAIT) ? STALL_W'(2'b11) : '0;
    // mispredicts under a mem stall are dropped; EX re-presents them later
    take = state == IDLE && p.ex_mispredict && !p.mem_stall_req && p.rdy;
    p.flush = p.rdy && (take || state != IDLE);
    p.redirect_valid = p.rdy && state == REDIRECT;
    state_nxt = state == IDLE ? (take ? WAIT : IDLE) :
                state == WAIT ? (p.if_busy ? WAIT : REDIRECT) :
                (p.mem_stall_req ? REDIRECT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      redirect_addr <= '0;
      stall_cycles <= STALL_CYCLES_INIT;
      flush_count <= FLUSH_COUNT_INIT;
    end else if (p.rdy) begin
      state <= state_nxt;
      if (take) redirect_addr <= p.ex_target;
      if (take) flush_count <= flush_count + 16'd1;
      if (p.stall_sign != '0 && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
  assign p.redirect_addr = redirect_addr;
  assign p.stall_cycles = stall_cycles;
  assign p.flush_count = flush_count;
endmodule
